req_ack_tx: RTL

REQ_ACK_TX -- requirements
Module: req_ack_tx

---
 rtl/req_ack_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/req_ack_tx.sv
`default_nettype none
// ============================================================================
//  Module      : req_ack_tx
//  Description : Transmit side of a 4-phase req/ack handshake toward an
//                asynchronous remote domain. Accepts one word from local
//                logic, holds it on data_out, raises req_out, waits for the
//                synchronized ack to rise and fall, then pulses done. A wait
//                that exceeds TIMEOUT cycles parks the block in an error state
//                until clr_err is asserted with the remote ack low.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_ack_tx #(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              req_out,
    input  logic              ack_in,
    output logic              done,
    output logic              busy,
    output logic              timeout_err,
    input  logic              clr_err
);

    // Counter just wide enough to hold TIMEOUT
    localparam int                c_cnt_w   = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [c_cnt_w-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic                     err_q, err_d;
    logic                     done_q, done_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic                     ack_s;

    // Synchronizer shift: stage 0 samples the asynchronous ack, the last
    // stage is the only copy the rest of the logic may look at
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ack_in};
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    // Moore-style outputs decoded straight from the current state
    assign tx_ready    = (state_q == ST_IDLE) && !ack_s;
    assign req_out     = (state_q == ST_REQ);
    assign busy        = (state_q != ST_IDLE);
    assign data_out    = data_q;
    assign done        = done_q;
    assign timeout_err = err_q;

    // Next-state, wait counter, data capture and error flag
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (tx_valid && tx_ready) begin
                    data_d  = tx_data;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Exit condition is tested first so it wins over a timeout
                if (ack_s) begin
                    state_d = ST_REL;
                    cnt_d   = '0;
                end else if (cnt_q == c_timeout) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REL: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == c_timeout) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ERR: begin
                cnt_d = '0;
                // Leaving with the remote ack still high would start the
                // next transfer against a stale acknowledge
                if (clr_err && !ack_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register with synchronous reset overriding every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            done_q  <= done_d;
            sync_q  <= sync_d;
        end
    end

endmodule
`default_nettype wire
